// File: rtl/line_buffer_sequencer_if.sv
// Purpose: pixel-stream handshake, line-buffer control and window-report signals of the sequencer.
// Latency: wires only; timing is owned by the endpoints.
// Backpressure: pixel_ready is driven by the sequencer from down_ready; the source must hold pixel_valid.
//
// Signals:
//   pixel_valid       source has a pixel
//   pixel_ready       sequencer accepts a pixel this cycle
//   down_ready        downstream window consumer can take a window this cycle
//   line_write_enable line buffer write/shift strobe (one per accepted pixel)
//   line_addr         current column address into the line buffer
//   window_valid      one-cycle pulse: the window ending at window_col/window_row is complete
//   window_col        column of the right-most window pixel
//   window_row        row of the bottom window pixel
// Modports: master = pixel source / window consumer side, slave = sequencer side.
interface line_buffer_sequencer_if #(
  parameter int AddrWidth = 3,
  parameter int RowWidth  = 3
);
  logic                 pixel_valid;
  logic                 pixel_ready;
  logic                 down_ready;
  logic                 line_write_enable;
  logic [AddrWidth-1:0] line_addr;
  logic                 window_valid;
  logic [AddrWidth-1:0] window_col;
  logic [RowWidth-1:0]  window_row;

  modport master (
    output pixel_valid,
    output down_ready,
    input  pixel_ready,
    input  line_write_enable,
    input  line_addr,
    input  window_valid,
    input  window_col,
    input  window_row
  );

  modport slave (
    input  pixel_valid,
    input  down_ready,
    output pixel_ready,
    output line_write_enable,
    output line_addr,
    output window_valid,
    output window_col,
    output window_row
  );
endinterface

// File: rtl/line_buffer_sequencer.sv
// Purpose: sequences the line-buffer bank over one raster frame and flags complete n x n windows.
// Latency: line_write_enable/line_addr combinational in the accept cycle; window_valid and frame_done one cycle later.
// Backpressure: pixel_ready follows down_ready while a frame is active; stalls freeze every counter.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset (wins over start)
//   start      begins a frame; only looked at while idle
//   busy       high whenever the sequencer is not idle
//   frame_done one-cycle pulse the cycle after the last pixel of the frame is accepted
//   bus        pixel handshake, line-buffer control and window report (slave side)
module line_buffer_sequencer #(
  parameter int AddrWidth   = 3,
  parameter int ImageWidth  = 7,
  parameter int ImageHeight = 5,
  parameter int RowWidth    = 3,
  parameter int WindowSize  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    frame_done,
  line_buffer_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [RowWidth-1:0]  row;
    logic [AddrWidth-1:0] col;
  } win_coord_t;

  localparam logic [AddrWidth-1:0] LastCol      = AddrWidth'(ImageWidth - 1);
  localparam logic [AddrWidth-1:0] FirstFullCol = AddrWidth'(WindowSize - 1);
  localparam logic [RowWidth-1:0]  LastFillRow  = RowWidth'(WindowSize - 2);
  localparam logic [RowWidth-1:0]  FirstFullRow = RowWidth'(WindowSize - 1);
  localparam logic [RowWidth-1:0]  LastRow      = RowWidth'(ImageHeight - 1);

  state_t               state;
  state_t               state_next;
  logic [AddrWidth-1:0] col;
  logic [AddrWidth-1:0] col_next;
  logic [RowWidth-1:0]  row;
  logic [RowWidth-1:0]  row_next;

  logic       active;
  logic       accept;
  logic       col_wrap;
  logic       window_hit;
  logic       win_vld;
  win_coord_t win_coord;
  logic       frame_done_q;

  assign active   = (state == FILL) || (state == RUN);
  assign accept   = bus.pixel_valid && bus.pixel_ready;
  assign col_wrap = (col == LastCol);

  // The window is complete once the accepted pixel sits at least n-1 rows and
  // n-1 columns into the frame: the line buffer then holds the n-1 rows above
  // and the incoming pixel closes the bottom-right corner.
  assign window_hit = accept && (row >= FirstFullRow) && (col >= FirstFullCol);

  assign bus.pixel_ready       = active && bus.down_ready;
  assign bus.line_write_enable = accept;
  assign bus.line_addr         = col;
  assign bus.window_valid      = win_vld;
  assign bus.window_col        = win_coord.col;
  assign bus.window_row        = win_coord.row;
  assign busy                  = (state != IDLE);
  assign frame_done            = frame_done_q;

  always_comb begin
    state_next = state;
    col_next   = col;
    row_next   = row;

    // Position counters only move on an accepted pixel; they never move in IDLE/DONE
    // because pixel_ready is held low there.
    if (accept) begin
      if (col_wrap) begin
        col_next = '0;
        row_next = row + RowWidth'(1);
      end else begin
        col_next = col + AddrWidth'(1);
      end
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_next = FILL;
          col_next   = '0;
          row_next   = '0;
        end
      end
      FILL: begin
        if (accept && col_wrap && (row == LastFillRow)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (accept && col_wrap && (row == LastRow)) begin
          state_next = DONE;
          // Park the row at zero rather than letting it run past the frame.
          row_next   = '0;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      win_vld      <= 1'b0;
      win_coord    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_next;
      col          <= col_next;
      row          <= row_next;
      win_vld      <= window_hit;
      // Coordinates hold between windows so the consumer may sample them late.
      if (window_hit) begin
        win_coord <= '{row: row, col: col};
      end
      // Registered from the next state so the pulse lines up exactly with DONE.
      frame_done_q <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_line_buffer_sequencer.sv
module tb_line_buffer_sequencer;
  localparam int AW = 3;
  localparam int RW = 3;
  localparam int W  = 7;
  localparam int H  = 5;
  localparam int N  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic frame_done;

  line_buffer_sequencer_if #(.AddrWidth(AW), .RowWidth(RW)) bus ();

  line_buffer_sequencer #(
    .AddrWidth(AW), .ImageWidth(W), .ImageHeight(H), .RowWidth(RW), .WindowSize(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .frame_done(frame_done),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame progress is just the number of accepted pixels.
  bit m_active, m_done, m_wv;
  int m_k, m_wc, m_wr;

  // Per-frame observations of the DUT.
  int writes, tcnt, last_lwe_t, fd_t;
  logic [5:0] win_q[$];
  logic [5:0] exp_q[$];
  logic s_busy, s_wv;
  logic [AW-1:0] s_addr;

  typedef struct {
    logic r, s, pv, dr;
    logic e_ready, e_lwe;
    int   e_addr;
    logic e_busy, e_wv, e_fd;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_wv = 0; m_k = 0; m_wc = 0; m_wr = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; bus.pixel_valid = 1'b0; bus.down_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cycle(input logic r, input logic s, input logic pv, input logic dr);
    bit acc, was_idle;
    int col, row;
    rst = r; start = s; bus.pixel_valid = pv; bus.down_ready = dr;
    @(negedge clk);
    chk("pixel_ready", bus.pixel_ready, m_active && dr);
    chk("line_write_enable", bus.line_write_enable, m_active && dr && pv);
    chk("line_addr", bus.line_addr, m_k % W);
    chk("busy", busy, m_active || m_done);
    chk("frame_done", frame_done, m_done);
    chk("window_valid", bus.window_valid, m_wv);
    chk("window_col", bus.window_col, m_wc);
    chk("window_row", bus.window_row, m_wr);
    s_busy = busy; s_wv = bus.window_valid; s_addr = bus.line_addr;
    if (bus.window_valid === 1'b1) win_q.push_back({bus.window_col, bus.window_row});
    if (bus.line_write_enable === 1'b1) begin writes++; last_lwe_t = tcnt; end
    if (frame_done === 1'b1 && fd_t < 0) fd_t = tcnt;
    tcnt++;
    acc = m_active && dr && pv;
    @(posedge clk); #1;
    if (r) begin
      model_reset();
    end else begin
      was_idle = !m_active && !m_done;
      m_wv = 0;
      m_done = 0;
      if (acc) begin
        col = m_k % W;
        row = m_k / W;
        if (row >= N - 1 && col >= N - 1) begin m_wv = 1; m_wc = col; m_wr = row; end
        m_k++;
        if (m_k == W * H) begin m_active = 0; m_done = 1; end
      end
      if (was_idle && s) begin m_active = 1; m_k = 0; end
    end
  endtask

  // mode 0: always valid/ready, 1: down_ready low every 3rd cycle,
  // 2: pixel_valid random 50%, 3: both random.
  task automatic run_frame(input int mode, input int start_at, input int rst_at);
    int cyc;
    logic pv, dr, r, s;
    writes = 0; tcnt = 0; last_lwe_t = -1; fd_t = -1;
    win_q.delete();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cyc = 0;
    while (!m_done && cyc < 600) begin
      pv = 1'b1; dr = 1'b1;
      if (mode == 1) dr = (cyc % 3 != 2);
      if (mode == 2) pv = $urandom_range(1, 0) == 1;
      if (mode == 3) begin pv = $urandom_range(1, 0) == 1; dr = $urandom_range(3, 0) != 0; end
      r = (rst_at >= 0 && m_k == rst_at);
      s = (start_at >= 0 && m_k == start_at);
      cycle(r, s, pv, dr);
      cyc++;
      if (r) return;
    end
    if (!m_done) chk("frame_timeout", cyc, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic cmp_frame(input string tag);
    chk({tag, "_writes"}, writes, W * H);
    chk({tag, "_win_count"}, win_q.size(), (W - N + 1) * (H - N + 1));
    for (int i = 0; i < win_q.size() && i < exp_q.size(); i++)
      chk({tag, "_win_coord"}, win_q[i], exp_q[i]);
    chk({tag, "_fd_delay"}, fd_t - last_lwe_t, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] tmp;
    for (int r = N - 1; r < H; r++)
      for (int c = N - 1; c < W; c++) begin
        tmp = {3'(c), 3'(r)};
        exp_q.push_back(tmp);
      end

    //            r  s  pv dr  rdy lwe addr busy wv fd
    vecs[0]  = '{0, 0, 1, 1,  0,  0,  0,  0,  0, 0};
    vecs[1]  = '{0, 0, 1, 1,  0,  0,  0,  0,  0, 0};
    vecs[2]  = '{0, 1, 1, 1,  0,  0,  0,  0,  0, 0};
    vecs[3]  = '{0, 0, 1, 1,  1,  1,  0,  1,  0, 0};
    vecs[4]  = '{0, 0, 1, 0,  0,  0,  1,  1,  0, 0};
    vecs[5]  = '{0, 0, 0, 1,  1,  0,  1,  1,  0, 0};
    vecs[6]  = '{0, 0, 1, 1,  1,  1,  1,  1,  0, 0};
    vecs[7]  = '{1, 1, 1, 1,  1,  1,  2,  1,  0, 0};
    vecs[8]  = '{0, 0, 1, 1,  0,  0,  0,  0,  0, 0};
    vecs[9]  = '{0, 1, 0, 0,  0,  0,  0,  0,  0, 0};
    vecs[10] = '{0, 0, 0, 1,  1,  0,  0,  1,  0, 0};
    vecs[11] = '{0, 0, 1, 1,  1,  1,  0,  1,  0, 0};

    bus.pixel_valid = 1'b0;
    bus.down_ready  = 1'b0;
    @(posedge clk);
    do_reset();
    chk("reset_busy", busy, 0);
    chk("reset_window_valid", bus.window_valid, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_line_addr", bus.line_addr, 0);

    for (int i = 0; i < 12; i++) begin
      rst = vecs[i].r; start = vecs[i].s;
      bus.pixel_valid = vecs[i].pv; bus.down_ready = vecs[i].dr;
      @(negedge clk);
      chk("vec_pixel_ready", bus.pixel_ready, vecs[i].e_ready);
      chk("vec_line_write_enable", bus.line_write_enable, vecs[i].e_lwe);
      chk("vec_line_addr", bus.line_addr, vecs[i].e_addr);
      chk("vec_busy", busy, vecs[i].e_busy);
      chk("vec_window_valid", bus.window_valid, vecs[i].e_wv);
      chk("vec_frame_done", frame_done, vecs[i].e_fd);
      @(posedge clk); #1;
    end
    do_reset();

    // Idle with pixels offered and no start: nothing may move.
    repeat (20) cycle(1'b0, 1'b0, 1'b1, 1'b1);

    run_frame(0, -1, -1);
    cmp_frame("t1");
    chk("t1_first_win", (win_q.size() > 0) ? win_q[0] : 6'h3f, {3'd2, 3'd2});
    chk("t1_last_win", (win_q.size() > 0) ? win_q[win_q.size() - 1] : 6'h3f, {3'd6, 3'd4});

    run_frame(1, -1, -1);
    cmp_frame("t2");

    run_frame(2, -1, -1);
    cmp_frame("t3");

    run_frame(0, 10, -1);
    cmp_frame("t4");

    run_frame(0, -1, 20);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5_busy_after_reset", s_busy, 0);
    chk("t5_addr_after_reset", s_addr, 0);
    chk("t5_wv_after_reset", s_wv, 0);
    run_frame(2, -1, -1);
    cmp_frame("t5");

    run_frame(3, -1, -1);
    cmp_frame("t7");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
